// File: rtl/hazard_fwd_ctrl.sv
// Decode-stage hazard and forwarding controller.
// Tracks in-flight writers and derives stall, forward selects and stall count.
module hazard_fwd_ctrl #(
  parameter int NSRC = 3,
  parameter int NSTG = 4,
  parameter int AW   = 5,
  parameter int TW   = 2,
  parameter int SW   = 3,
  parameter int CW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [NSRC*AW-1:0] id_src,
  input  logic [NSRC*TW-1:0] id_tuse,
  input  logic [AW-1:0]     id_dst,
  input  logic [TW-1:0]     id_tnew,
  input  logic              id_md,
  input  logic              md_busy,
  input  logic              flush,
  output logic              stall,
  output logic [NSRC*SW-1:0] fwd_sel,
  output logic [NSTG-1:0]   stg_valid,
  output logic [CW-1:0]     stall_cnt
);

  logic [NSTG-1:0] vld_q, vld_d;
  logic [AW-1:0]   dst_q  [NSTG];
  logic [AW-1:0]   dst_d  [NSTG];
  logic [TW-1:0]   tnew_q [NSTG];
  logic [TW-1:0]   tnew_d [NSTG];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NSRC-1:0] haz;
  logic            load1;

  // Youngest matching stage decides hazard and forward source per operand
  always_comb begin
    haz     = '0;
    fwd_sel = '0;
    for (int j = 0; j < NSRC; j++) begin
      for (int k = NSTG - 1; k >= 0; k--) begin
        if (id_src[j*AW +: AW] != '0 && vld_q[k] &&
            dst_q[k] == id_src[j*AW +: AW]) begin
          haz[j] = tnew_q[k] > id_tuse[j*TW +: TW];
          fwd_sel[j*SW +: SW] = (tnew_q[k] == '0) ?
                                SW'(k + 1) : '0;
        end
      end
    end
  end

  assign stall = id_valid & ~flush &
                 ((|haz) | (id_md & md_busy));

  assign load1     = id_valid & ~stall & ~flush;
  assign stg_valid = vld_q;
  assign stall_cnt = cnt_q;

  // Scoreboard advance: stage 1 loads decode, flush kills stages 1 and 2
  always_comb begin
    vld_d     = '0;
    dst_d[0]  = '0;
    tnew_d[0] = '0;
    if (load1) begin
      vld_d[0]  = 1'b1;
      dst_d[0]  = id_dst;
      tnew_d[0] = id_tnew;
    end
    for (int k = 1; k < NSTG; k++) begin
      vld_d[k]  = vld_q[k-1];
      dst_d[k]  = dst_q[k-1];
      tnew_d[k] = (tnew_q[k-1] == '0) ? '0 :
                  tnew_q[k-1] - 1'b1;
      if (k == 1 && flush) begin
        vld_d[k]  = 1'b0;
        dst_d[k]  = '0;
        tnew_d[k] = '0;
      end
    end
  end

  // Saturating stall-cycle counter
  always_comb begin
    cnt_d = cnt_q;
    if (stall && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  // Scoreboard and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < NSTG; k++) begin
        dst_q[k]  <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < NSTG; k++) begin
        dst_q[k]  <= dst_d[k];
        tnew_q[k] <= tnew_d[k];
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl.
// Hand-computed expectations for stall, forwarding, flush and counter.
module tb_hazard_fwd_ctrl;

  localparam int NSRC = 3;
  localparam int NSTG = 4;
  localparam int AW   = 5;
  localparam int TW   = 2;
  localparam int SW   = 3;
  localparam int CW   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [NSRC*AW-1:0] id_src;
  logic [NSRC*TW-1:0] id_tuse;
  logic [AW-1:0]     id_dst;
  logic [TW-1:0]     id_tnew;
  logic              id_md;
  logic              md_busy;
  logic              flush;
  logic              stall;
  logic [NSRC*SW-1:0] fwd_sel;
  logic [NSTG-1:0]   stg_valid;
  logic [CW-1:0]     stall_cnt;

  int errs = 0;
  int nchk = 0;

  hazard_fwd_ctrl #(
    .NSRC(NSRC), .NSTG(NSTG), .AW(AW),
    .TW(TW), .SW(SW), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_src(id_src),
    .id_tuse(id_tuse), .id_dst(id_dst),
    .id_tnew(id_tnew), .id_md(id_md),
    .md_busy(md_busy), .flush(flush),
    .stall(stall), .fwd_sel(fwd_sel),
    .stg_valid(stg_valid), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic drive(input logic v,
                       input logic [AW-1:0] s0,
                       input logic [AW-1:0] s1,
                       input logic [AW-1:0] s2,
                       input logic [TW-1:0] u0,
                       input logic [TW-1:0] u1,
                       input logic [TW-1:0] u2,
                       input logic [AW-1:0] d,
                       input logic [TW-1:0] t);
    id_valid = v;
    id_src   = {s2, s1, s0};
    id_tuse  = {u2, u1, u0};
    id_dst   = d;
    id_tnew  = t;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    id_md   = 0;
    md_busy = 0;
    flush   = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    #1;
    rst = 1;
  endtask

  initial begin
    rst = 0;
    idle();
    #2;
    check("rst_stall", 32'(stall), 0);
    check("rst_fwd", 32'(fwd_sel), 0);
    check("rst_vld", 32'(stg_valid), 0);
    check("rst_cnt", 32'(stall_cnt), 0);
    rst = 1;
    tick();

    // ALU r3 then dependent ALU
    drive(1, 0, 0, 0, 0, 0, 0, 3, 1);
    #1 check("t1_w_stall", 32'(stall), 0);
    tick();
    drive(1, 3, 0, 0, 1, 0, 0, 0, 0);
    #1 check("t1_r_stall", 32'(stall), 0);
    check("t1_r_fwd0", 32'(fwd_sel), 0);
    tick();
    #1 check("t1_fwdM", 32'(fwd_sel[2:0]), 2);
    check("t1_stall2", 32'(stall), 0);
    check("t1_vld", 32'(stg_valid), 4'b0011);

    // load r4 then beq r4
    do_reset();
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 4, 2);
    tick();
    drive(1, 4, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t2_stall_a", 32'(stall), 1);
    tick();
    #1 check("t2_stall_b", 32'(stall), 1);
    check("t2_cnt1", 32'(stall_cnt), 1);
    tick();
    #1 check("t2_stall_c", 32'(stall), 0);
    check("t2_fwd", 32'(fwd_sel), 3);
    check("t2_cnt2", 32'(stall_cnt), 2);

    // youngest writer wins, src 0 never forwards
    do_reset();
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 6, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 6, 0);
    tick();
    drive(1, 6, 0, 6, 0, 0, 0, 0, 0);
    #1 check("t3_fwd", 32'(fwd_sel), {3'd1, 3'd0, 3'd1});
    check("t3_stall", 32'(stall), 0);
    do_reset();
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 7, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 7, 1);
    tick();
    drive(1, 7, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t3_old_ign_st", 32'(stall), 1);
    check("t3_old_ign_fw", 32'(fwd_sel), 0);

    // multi-cycle busy interlock
    do_reset();
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    id_md   = 1;
    md_busy = 1;
    for (int i = 0; i < 5; i++) begin
      #1 check("t4_md_stall", 32'(stall), 1);
      tick();
    end
    md_busy = 0;
    #1 check("t4_md_free", 32'(stall), 0);
    check("t4_cnt5", 32'(stall_cnt), 5);
    md_busy = 1;
    flush   = 1;
    #1 check("t4_md_flush", 32'(stall), 0);
    idle();

    // flush kills stages 1 and 2 only
    do_reset();
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 9, 2);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 5, 2);
    tick();
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
    flush = 1;
    #1 check("t5_fl_stall", 32'(stall), 0);
    tick();
    flush = 0;
    #1 check("t5_vld", 32'(stg_valid), 4'b0100);
    check("t5_r5_stall", 32'(stall), 0);
    check("t5_r5_fwd", 32'(fwd_sel), 0);
    drive(1, 9, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t5_r9_fwd", 32'(fwd_sel), 3);

    // async reset mid-stall
    do_reset();
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 4, 2);
    tick();
    drive(1, 4, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t6_pre_stall", 32'(stall), 1);
    tick();
    #1 check("t6_pre_cnt", 32'(stall_cnt), 1);
    rst = 0;
    #1 check("t6_stall", 32'(stall), 0);
    check("t6_fwd", 32'(fwd_sel), 0);
    check("t6_vld", 32'(stg_valid), 0);
    check("t6_cnt", 32'(stall_cnt), 0);
    rst = 1;

    // counter saturation
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    id_md   = 1;
    md_busy = 1;
    for (int i = 0; i < 20; i++) tick();
    check("t6_sat", 32'(stall_cnt), 15);
    check("t6_sat_st", 32'(stall), 1);
    tick();
    check("t6_sat_hold", 32'(stall_cnt), 15);
    idle();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
